// File: rtl/wb_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and helpers for the Wishbone timer bank.
package wb_timer_pkg;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_RELOAD  = 2'd1;
   localparam logic [1:0] REG_COUNT   = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;
   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_START   = 2'd1;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_ONESHOT = 1;
   localparam int unsigned CTRL_DOWN    = 2;
   localparam int unsigned CTRL_IE      = 3;
   localparam int unsigned CTRL_PRE_LSB = 8;
   localparam int unsigned STAT_EXPIRED = 0;
   localparam int unsigned STAT_RUNNING = 1;

   localparam logic [3:0] GLOBAL_CH = 4'hF;

   typedef struct packed {
      logic [7:0] prescale;
      logic       ie;
      logic       down;
      logic       oneshot;
      logic       en;
   } ctrl_t;

   // Replace only the byte lanes selected by sel.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
      logic [31:0] w;
      w = '0;
      w[CTRL_EN]              = c.en;
      w[CTRL_ONESHOT]         = c.oneshot;
      w[CTRL_DOWN]            = c.down;
      w[CTRL_IE]              = c.ie;
      w[CTRL_PRE_LSB +: 8]    = c.prescale;
      return w;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control register, prescaler, reload/count registers and sticky expiry flag.
module timer_channel
   import wb_timer_pkg::*;
#(
   parameter int unsigned CNT_W = 32
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ctrl_we_i,
   input  logic             reload_we_i,
   input  logic             count_we_i,
   input  logic             status_we_i,
   input  logic             start_i,
   input  logic [3:0]       sel_i,
   input  logic [31:0]      wdat_i,
   output ctrl_t            ctrl_o,
   output logic [CNT_W-1:0] reload_o,
   output logic [CNT_W-1:0] count_o,
   output logic             expired_o
);

   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       presc_q, presc_d;
   logic             expired_q, expired_d;
   logic             run, tick, at_term, expire;

   always_comb begin
      ctrl_d    = ctrl_q;
      reload_d  = reload_q;
      count_d   = count_q;
      presc_d   = presc_q;
      expired_d = expired_q;
      run       = 1'b0;
      tick      = 1'b0;
      at_term   = 1'b0;
      expire    = 1'b0;

      if (ctrl_we_i && sel_i[0]) begin
         ctrl_d.en      = wdat_i[CTRL_EN];
         ctrl_d.oneshot = wdat_i[CTRL_ONESHOT];
         ctrl_d.down    = wdat_i[CTRL_DOWN];
         ctrl_d.ie      = wdat_i[CTRL_IE];
      end
      if (ctrl_we_i && sel_i[1]) ctrl_d.prescale = wdat_i[CTRL_PRE_LSB +: 8];
      if (start_i) ctrl_d.en = 1'b1;

      // A write that clears EN in this cycle freezes the channel at this edge.
      run     = ctrl_q.en & ctrl_d.en;
      tick    = run && (presc_q == ctrl_q.prescale);
      at_term = ctrl_q.down ? (count_q == '0) : (count_q == reload_q);
      expire  = tick & at_term;

      if (run) presc_d = tick ? 8'd0 : presc_q + 8'd1;
      if (!ctrl_q.en && ctrl_d.en) presc_d = 8'd0;

      if (tick) begin
         if (!expire)
            count_d = ctrl_q.down ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
         else if (!ctrl_q.oneshot)
            count_d = ctrl_q.down ? reload_q : '0;
      end
      if (expire && ctrl_q.oneshot) ctrl_d.en = 1'b0;

      if (count_we_i) begin
         count_d = CNT_W'(byte_merge(32'(count_q), wdat_i, sel_i));
         presc_d = 8'd0;
      end
      if (reload_we_i) reload_d = CNT_W'(byte_merge(32'(reload_q), wdat_i, sel_i));

      if (status_we_i && sel_i[0] && wdat_i[STAT_EXPIRED]) expired_d = 1'b0;
      if (expire) expired_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         reload_q  <= '0;
         count_q   <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         reload_q  <= reload_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
      end
   end

   assign ctrl_o    = ctrl_q;
   assign reload_o  = reload_q;
   assign count_o   = count_q;
   assign expired_o = expired_q;

endmodule

// File: rtl/wb_timer_bank.sv
// Multi-channel Wishbone timer bank: bus decode, registered ack/read data, per-channel
// write strobes, synchronised start and the level interrupt.
module wb_timer_bank
   import wb_timer_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
)(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        irq_o
);

   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic              hit, wr, start_wr;
   logic [3:0]        ch_idx;
   logic [1:0]        reg_idx;
   logic [31:0]       rdata;
   logic              unused_adr;

   logic [NUM_CH-1:0] ctrl_we, reload_we, count_we, status_we, start;
   logic [NUM_CH-1:0] expired, ie_vec, pending;
   ctrl_t             ch_ctrl   [NUM_CH];
   logic [CNT_W-1:0]  ch_reload [NUM_CH];
   logic [CNT_W-1:0]  ch_count  [NUM_CH];

   assign ch_idx     = wb_adr_i[7:4];
   assign reg_idx    = wb_adr_i[3:2];
   assign unused_adr = ^wb_adr_i[1:0];

   // Holding off while ack is high gives exactly one ack per access.
   assign hit      = wb_cyc_i & wb_stb_i & ~ack_q & (wb_adr_i[31:8] == BASE_ADDR[31:8]);
   assign wr       = hit & wb_we_i;
   assign start_wr = wr && (ch_idx == GLOBAL_CH) && (reg_idx == REG_START);

   for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
      logic ch_wr;
      assign ch_wr        = wr && (ch_idx == 4'(i));
      assign ctrl_we[i]   = ch_wr && (reg_idx == REG_CTRL);
      assign reload_we[i] = ch_wr && (reg_idx == REG_RELOAD);
      assign count_we[i]  = ch_wr && (reg_idx == REG_COUNT);
      assign status_we[i] = ch_wr && (reg_idx == REG_STATUS);
      assign start[i]     = start_wr & wb_dat_i[i] & wb_sel_i[i/8];
      assign ie_vec[i]    = ch_ctrl[i].ie;

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk_i       (wb_clk_i),
         .rst_i       (wb_rst_i),
         .ctrl_we_i   (ctrl_we[i]),
         .reload_we_i (reload_we[i]),
         .count_we_i  (count_we[i]),
         .status_we_i (status_we[i]),
         .start_i     (start[i]),
         .sel_i       (wb_sel_i),
         .wdat_i      (wb_dat_i),
         .ctrl_o      (ch_ctrl[i]),
         .reload_o    (ch_reload[i]),
         .count_o     (ch_count[i]),
         .expired_o   (expired[i])
      );
   end

   assign pending = expired & ie_vec;
   assign irq_o   = |pending;

   // Read mux; unmapped channels and offsets read as zero.
   always_comb begin
      rdata = '0;
      if (ch_idx == GLOBAL_CH) begin
         if (reg_idx == REG_PENDING) rdata = 32'(pending);
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_idx == 4'(i)) begin
               case (reg_idx)
                  REG_CTRL:   rdata = ctrl_to_word(ch_ctrl[i]);
                  REG_RELOAD: rdata = 32'(ch_reload[i]);
                  REG_COUNT:  rdata = 32'(ch_count[i]);
                  default: begin
                     rdata[STAT_EXPIRED] = expired[i];
                     rdata[STAT_RUNNING] = ch_ctrl[i].en;
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      ack_d = hit;
      dat_d = (hit && !wb_we_i) ? rdata : '0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_timer_bank.sv
// Randomised scoreboard bench for wb_timer_bank against a cycle-level behavioural model.
module tb_wb_timer_bank;

   localparam int NCH = 4;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat, dat_o;
   logic        ack, irq;

   always #5 clk = ~clk;

   wb_timer_bank #(.NUM_CH(NCH), .CNT_W(32), .BASE_ADDR(BASE)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_sel_i (sel),
      .wb_adr_i (adr),
      .wb_dat_i (dat),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .irq_o    (irq)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { logic [31:0] a; logic [31:0] d; } rd_t;
   rd_t rq[$];

   // Reference model state
   logic        m_en [NCH], m_one [NCH], m_down [NCH], m_ie [NCH], m_exp [NCH];
   logic [7:0]  m_pre [NCH];
   logic [31:0] m_rel [NCH], m_cnt [NCH];
   int          m_ps [NCH];
   logic        m_ack = 1'b0, m_ack_rd = 1'b0;

   function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      int c, r;
      logic [31:0] v;
      c = int'(a[7:4]);
      r = int'(a[3:2]);
      v = 32'd0;
      if (c == 15) begin
         if (r == 0)
            for (int k = 0; k < NCH; k++) v[k] = m_exp[k] & m_ie[k];
      end else if (c < NCH) begin
         case (r)
            0: v = {16'd0, m_pre[c], 4'd0, m_ie[c], m_down[c], m_one[c], m_en[c]};
            1: v = m_rel[c];
            2: v = m_cnt[c];
            default: v = {30'd0, m_en[c], m_exp[c]};
         endcase
      end
      return v;
   endfunction

   // Model: advances one clock at every rising edge using the bus inputs then present.
   initial begin : model
      logic hit;
      int c, r;
      for (int k = 0; k < NCH; k++) begin
         m_en[k] = 0; m_one[k] = 0; m_down[k] = 0; m_ie[k] = 0; m_exp[k] = 0;
         m_pre[k] = 0; m_rel[k] = 0; m_cnt[k] = 0; m_ps[k] = 0;
      end
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int k = 0; k < NCH; k++) begin
               m_en[k] = 0; m_one[k] = 0; m_down[k] = 0; m_ie[k] = 0; m_exp[k] = 0;
               m_pre[k] = 0; m_rel[k] = 0; m_cnt[k] = 0; m_ps[k] = 0;
            end
            m_ack = 0;
            m_ack_rd = 0;
         end else begin
            hit = cyc && stb && !m_ack && (adr[31:8] == BASE[31:8]);
            c = int'(adr[7:4]);
            r = int'(adr[3:2]);
            if (hit && !we) rq.push_back('{a: adr, d: mread(adr)});
            for (int k = 0; k < NCH; k++) begin
               logic wc, en_n, one_n, down_n, ie_n, run, tick, fire, exp_n;
               logic [7:0] pre_n;
               logic [31:0] cnt_n, rel_n;
               int ps_n;
               wc = hit && we && (c == k);
               en_n = m_en[k]; one_n = m_one[k]; down_n = m_down[k]; ie_n = m_ie[k];
               pre_n = m_pre[k]; rel_n = m_rel[k]; cnt_n = m_cnt[k]; exp_n = m_exp[k];
               if (wc && r == 0 && sel[0]) {ie_n, down_n, one_n, en_n} = dat[3:0];
               if (wc && r == 0 && sel[1]) pre_n = dat[15:8];
               if (hit && we && c == 15 && r == 1 && sel[0] && dat[k]) en_n = 1;
               run  = m_en[k] && en_n;
               tick = run && (m_ps[k] == int'(m_pre[k]));
               fire = tick && (m_down[k] ? (m_cnt[k] == 0) : (m_cnt[k] == m_rel[k]));
               if (tick && !fire) cnt_n = m_down[k] ? m_cnt[k] - 1 : m_cnt[k] + 1;
               else if (fire && !m_one[k]) cnt_n = m_down[k] ? m_rel[k] : 32'd0;
               ps_n = m_ps[k];
               if (run) ps_n = tick ? 0 : (m_ps[k] + 1) % 256;
               if (!m_en[k] && en_n) ps_n = 0;
               if (wc && r == 2) begin
                  cnt_n = lane_merge(m_cnt[k], dat, sel);
                  ps_n = 0;
               end
               if (wc && r == 1) rel_n = lane_merge(m_rel[k], dat, sel);
               if (wc && r == 3 && sel[0] && dat[0]) exp_n = 0;
               if (fire) exp_n = 1;
               if (fire && m_one[k]) en_n = 0;
               m_en[k] = en_n; m_one[k] = one_n; m_down[k] = down_n; m_ie[k] = ie_n;
               m_pre[k] = pre_n; m_rel[k] = rel_n; m_cnt[k] = cnt_n; m_exp[k] = exp_n;
               m_ps[k] = ps_n;
            end
            m_ack = hit;
            m_ack_rd = hit && !we;
         end
      end
   end

   // Monitor: compares ack, irq and read data against the model away from the rising edge.
   initial begin : monitor
      logic irq_exp;
      rd_t e;
      forever begin
         @(negedge clk);
         checks++;
         if (ack !== m_ack) begin
            errors++;
            $display("FAIL ack t=%0t got=%b exp=%b adr=%h", $time, ack, m_ack, adr);
         end
         irq_exp = 1'b0;
         for (int k = 0; k < NCH; k++) irq_exp = irq_exp | (m_exp[k] & m_ie[k]);
         checks++;
         if (irq !== irq_exp) begin
            errors++;
            $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, irq_exp);
         end
         if (ack && m_ack_rd) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL rd_underflow t=%0t got=%h exp=<none>", $time, dat_o);
            end else begin
               e = rq.pop_front();
               if (dat_o !== e.d) begin
                  errors++;
                  $display("FAIL rd_data t=%0t adr=%h got=%h exp=%h", $time, e.a, dat_o, e.d);
               end
            end
         end
      end
   end

   function automatic logic [31:0] ra(input int c, input int r);
      return BASE | (32'(c) << 4) | (32'(r) << 2);
   endfunction

   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      int n;
      cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ack && n < 4);
      checks++;
      if (!ack) begin
         errors++;
         $display("FAIL ack_timeout adr=%h got=no_ack exp=ack_within_1", a);
      end
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wr(input int c, input int r, input logic [31:0] d);
      access(1'b1, ra(c, r), d, 4'hF);
   endtask

   task automatic rd(input int c, input int r);
      access(1'b0, ra(c, r), 32'd0, 4'hF);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c, r, pick;
      logic [31:0] d;
      logic [3:0] s;
      rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Reset values of every mapped register
      for (int ch = 0; ch < NCH; ch++)
         for (int rg = 0; rg < 4; rg++) rd(ch, rg);
      rd(15, 0);
      rd(15, 1);

      // Periodic up-counter with interrupt
      wr(0, 1, 32'd3);
      wr(0, 0, 32'h09);
      for (int i = 0; i < 6; i++) rd(0, 2);
      rd(0, 3);
      rd(15, 0);
      wr(0, 0, 32'h08);
      wr(0, 3, 32'h1);
      rd(0, 3);

      // Down one-shot with prescaler
      wr(1, 1, 32'd9);
      wr(1, 2, 32'd2);
      wr(1, 0, 32'h0407);
      for (int i = 0; i < 10; i++) rd(1, 3);
      rd(1, 0);
      rd(1, 2);

      // Synchronised start
      for (int ch = 0; ch <= 2; ch += 2) begin
         wr(ch, 1, 32'd5);
         wr(ch, 2, 32'd0);
         wr(ch, 0, 32'h0100);
      end
      wr(15, 1, 32'h5);
      for (int i = 0; i < 8; i++) begin
         rd(0, 2);
         rd(2, 2);
      end
      wr(0, 0, 32'h0);
      wr(2, 0, 32'h0);

      // Contention: W1C and COUNT write on a ticking channel, plus wrap above RELOAD
      wr(3, 1, 32'd0);
      wr(3, 0, 32'h01);
      wr(3, 3, 32'h1);
      rd(3, 3);
      wr(3, 2, 32'd100);
      rd(3, 2);
      wr(3, 2, 32'hFFFF_FFFD);
      for (int i = 0; i < 4; i++) rd(3, 2);
      wr(3, 0, 32'h0);

      // Byte lanes, unmapped channel, foreign page
      access(1'b1, ra(2, 0), 32'hFFFF_FFFF, 4'b0010);
      rd(2, 0);
      wr(9, 0, 32'hFFFF_FFFF);
      rd(9, 0);
      rd(4, 1);
      cyc = 1; stb = 1; we = 0; adr = BASE + 32'h100; sel = 4'hF;
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (ack) begin
            errors++;
            $display("FAIL foreign_page got=ack exp=no_ack");
         end
      end
      cyc = 0; stb = 0;
      idle(1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         pick = int'($urandom_range(0, 6));
         c = (pick < 4) ? pick : (pick == 4) ? 15 : (pick == 5) ? 9 : int'($urandom_range(0, 3));
         r = int'($urandom_range(0, 3));
         d = $urandom;
         case (r)
            0: d[15:10] = 6'd0;
            1: d = 32'($urandom_range(0, 12));
            2: if ($urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 12));
            default: ;
         endcase
         s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         access(1'($urandom), ra(c, r), d, s);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(3);
      checks++;
      if (rq.size() != 0) begin
         errors++;
         $display("FAIL rd_leftover got=%0d exp=0", rq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
